// File: rtl/freq_meter.sv
// rtl/freq_meter.sv - gated rising-edge counter that measures a divided clock over a fixed window
// Counts synchronized rising edges of clk_in for GATE_CYCLES clk cycles, then strobes the result.
module freq_meter #(
    parameter int GATE_CYCLES = 1000,
    parameter int CNT_W       = 16,
    parameter int CONTINUOUS  = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clk_in,
    input  logic             start,
    output logic [CNT_W-1:0] meas_count,
    output logic             meas_valid,
    output logic             busy,
    output logic             overflow
);

    localparam int GW = $clog2(GATE_CYCLES);
    localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic {
        IDLE = 1'b0,
        GATE = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [GW-1:0]     gate_cnt_q, gate_cnt_d;
    logic [CNT_W-1:0]  edge_cnt_q, edge_cnt_d;
    logic              sat_q, sat_d;
    logic [CNT_W-1:0]  meas_count_q, meas_count_d;
    logic              meas_valid_q, meas_valid_d;
    logic              overflow_q, overflow_d;
    logic              busy_q, busy_d;
    logic              s1_q, s2_q, s3_q;

    logic              edge_p;
    logic              at_max;
    logic              sat_inc;
    logic [CNT_W-1:0]  edge_next;
    logic              win_end;

    // Synchronizer and history flop run in every state so the window never sees stale edges.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= clk_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign edge_p    = s2_q & ~s3_q;
    assign at_max    = (edge_cnt_q == CNT_MAX);
    assign sat_inc   = at_max & edge_p;
    assign edge_next = (edge_p && !at_max) ? edge_cnt_q + CNT_W'(1) : edge_cnt_q;
    assign win_end   = (state_q == GATE) && (gate_cnt_q == GATE_LAST);

    always_comb begin
        state_d      = state_q;
        gate_cnt_d   = gate_cnt_q;
        edge_cnt_d   = edge_cnt_q;
        sat_d        = sat_q;
        meas_count_d = meas_count_q;
        overflow_d   = overflow_q;
        meas_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = GATE;
                    gate_cnt_d = '0;
                    edge_cnt_d = '0;
                    sat_d      = 1'b0;
                end
            end
            GATE: begin
                gate_cnt_d = gate_cnt_q + GW'(1);
                edge_cnt_d = edge_next;
                sat_d      = sat_q | sat_inc;
                if (win_end) begin
                    meas_count_d = edge_next;
                    overflow_d   = sat_q | sat_inc;
                    meas_valid_d = 1'b1;
                    // Continuous mode re-arms in place so consecutive windows abut with no dead cycle.
                    gate_cnt_d   = '0;
                    edge_cnt_d   = '0;
                    sat_d        = 1'b0;
                    if (CONTINUOUS == 0) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == GATE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            gate_cnt_q   <= '0;
            edge_cnt_q   <= '0;
            sat_q        <= 1'b0;
            meas_count_q <= '0;
            meas_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            gate_cnt_q   <= gate_cnt_d;
            edge_cnt_q   <= edge_cnt_d;
            sat_q        <= sat_d;
            meas_count_q <= meas_count_d;
            meas_valid_q <= meas_valid_d;
            overflow_q   <= overflow_d;
            busy_q       <= busy_d;
        end
    end

    assign meas_count = meas_count_q;
    assign meas_valid = meas_valid_q;
    assign overflow   = overflow_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_freq_meter.sv
// tb/tb_freq_meter.sv - scoreboard bench for freq_meter over three parameter sets
`timescale 1ns/1ps
module tb_freq_meter;

    localparam int NCYC = 32768;
    localparam int GA = 1000;
    localparam int GB = 100;
    localparam int GC = 800;

    typedef struct {
        int cnt;
        bit ovf;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic        rst_n  [3];
    logic        clk_in [3];
    logic        start  [3];
    logic        valid  [3];
    logic        busy   [3];
    logic        ovf    [3];
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;
    logic [15:0] cnt_c;

    bit   wave [3][NCYC];
    exp_t qa[$], qb[$], qc[$];
    int   nvalid [3];
    int   errors = 0;
    int   checks = 0;

    freq_meter #(.GATE_CYCLES(GA), .CNT_W(16), .CONTINUOUS(0)) u_a (
        .clk(clk), .reset_n(rst_n[0]), .clk_in(clk_in[0]), .start(start[0]),
        .meas_count(cnt_a), .meas_valid(valid[0]), .busy(busy[0]), .overflow(ovf[0]));

    freq_meter #(.GATE_CYCLES(GB), .CNT_W(4), .CONTINUOUS(0)) u_b (
        .clk(clk), .reset_n(rst_n[1]), .clk_in(clk_in[1]), .start(start[1]),
        .meas_count(cnt_b), .meas_valid(valid[1]), .busy(busy[1]), .overflow(ovf[1]));

    freq_meter #(.GATE_CYCLES(GC), .CNT_W(16), .CONTINUOUS(1)) u_c (
        .clk(clk), .reset_n(rst_n[2]), .clk_in(clk_in[2]), .start(start[2]),
        .meas_count(cnt_c), .meas_valid(valid[2]), .busy(busy[2]), .overflow(ovf[2]));

    // wave[d][m] is the clk_in level present at rising edge m
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            clk_in[d] = (cyc + 1 < NCYC) ? wave[d][cyc + 1] : 1'b0;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int cnt_of(input int d);
        case (d)
            0: return int'(cnt_a);
            1: return int'(cnt_b);
            default: return int'(cnt_c);
        endcase
    endfunction

    function automatic int qsize(input int d);
        case (d)
            0: return qa.size();
            1: return qb.size();
            default: return qc.size();
        endcase
    endfunction

    task automatic push(input int d, input exp_t e);
        case (d)
            0: qa.push_back(e);
            1: qb.push_back(e);
            default: qc.push_back(e);
        endcase
    endtask

    // Reference: every 0->1 transition of clk_in inside the window, seen two clocks late, saturated to CNT_W bits.
    function automatic exp_t model(input int d, input int k, input int g, input int w);
        exp_t e;
        int rises = 0;
        int lim = (1 << w) - 1;
        for (int i = k - 1; i <= k + g - 2; i++) begin
            if (wave[d][i] && !wave[d][i - 1]) rises++;
        end
        e.cnt = (rises > lim) ? lim : rises;
        e.ovf = (rises > lim);
        e.cyc = k + g;
        return e;
    endfunction

    task automatic fill(input int d, input int from, input int len, input int half, input bit lvl, input int phase);
        for (int i = from; i < from + len && i < NCYC; i++) begin
            wave[d][i] = (half == 0) ? lvl : (((i + phase) / half) % 2 == 1);
        end
    endtask

    task automatic on_valid(input int d, input int c, input bit o, input bit b);
        exp_t e;
        bit have = 1'b1;
        nvalid[d]++;
        case (d)
            0: if (qa.size() > 0) e = qa.pop_front(); else have = 1'b0;
            1: if (qb.size() > 0) e = qb.pop_front(); else have = 1'b0;
            default: if (qc.size() > 0) e = qc.pop_front(); else have = 1'b0;
        endcase
        if (!have) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid dut%0d: got strobe with count %0d at cycle %0d expected none", d, c, cyc);
        end else begin
            chk($sformatf("count_dut%0d", d), c, e.cnt);
            chk($sformatf("overflow_dut%0d", d), int'(o), int'(e.ovf));
            chk($sformatf("latency_dut%0d", d), cyc, e.cyc);
            chk($sformatf("busy_at_valid_dut%0d", d), int'(b), (d == 2) ? 1 : 0);
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (valid[d] === 1'b1) on_valid(d, cnt_of(d), ovf[d], busy[d]);
        end
    end

    task automatic drain(input int d, input int budget);
        int n = 0;
        while (qsize(d) > 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (qsize(d) > 0) begin
            checks++;
            errors++;
            $display("FAIL timeout_dut%0d: got %0d strobes outstanding expected 0", d, qsize(d));
            case (d)
                0: qa.delete();
                1: qb.delete();
                default: qc.delete();
            endcase
        end
        @(posedge clk);
    endtask

    task automatic chk_zero(input int d, input string tag);
        chk($sformatf("%s_count_dut%0d", tag, d), cnt_of(d), 0);
        chk($sformatf("%s_valid_dut%0d", tag, d), int'(valid[d]), 0);
        chk($sformatf("%s_busy_dut%0d", tag, d), int'(busy[d]), 0);
        chk($sformatf("%s_ovf_dut%0d", tag, d), int'(ovf[d]), 0);
    endtask

    // Presets clk_in for `lead` cycles, then pulses start; returns the edge k at which start is sampled.
    task automatic open_window(input int d, input int g, input int w, input int half, input bit lvl,
                               input int lead, output int k);
        int c;
        @(posedge clk);
        #1;
        c = cyc;
        fill(d, c + 1, lead + g + 8, half, lvl, $urandom_range(0, 15));
        repeat (lead) @(posedge clk);
        #1;
        k = cyc + 1;
        push(d, model(d, k, g, w));
        start[d] = 1'b1;
        @(posedge clk);
        #1;
        start[d] = 1'b0;
    endtask

    task automatic run_a();
        int k;
        int n;
        open_window(0, GA, 16, 2, 1'b0, 0, k);
        n = 0;
        while (busy[0] && n < 2 * GA) begin
            n++;
            @(posedge clk);
            #1;
        end
        chk("busy_cycles_div4", n, GA);
        drain(0, 2 * GA);

        open_window(0, GA, 16, 0, 1'b0, 5, k);
        drain(0, 2 * GA);
        open_window(0, GA, 16, 0, 1'b1, 5, k);
        drain(0, 2 * GA);

        open_window(0, GA, 16, 2, 1'b0, 0, k);
        repeat (9) @(posedge clk);
        #1 start[0] = 1'b1;
        @(posedge clk);
        #1 start[0] = 1'b0;
        repeat (489) @(posedge clk);
        #1 start[0] = 1'b1;
        @(posedge clk);
        #1 start[0] = 1'b0;
        drain(0, 2 * GA);
        repeat (20) @(posedge clk);

        open_window(0, GA, 16, 2, 1'b0, 0, k);
        repeat (400) @(posedge clk);
        #3 rst_n[0] = 1'b0;
        #1 chk_zero(0, "midreset");
        void'(qa.pop_back());
        @(posedge clk);
        @(posedge clk);
        #2 rst_n[0] = 1'b1;
        nvalid[0] = 0;
        repeat (1100) @(posedge clk);
        chk("strobes_after_reset", nvalid[0], 0);
        open_window(0, GA, 16, 2, 1'b0, 0, k);
        drain(0, 2 * GA);

        for (int r = 0; r < 3; r++) begin
            open_window(0, GA, 16, $urandom_range(0, 7), 1'($urandom_range(0, 1)), $urandom_range(0, 3), k);
            drain(0, 2 * GA);
        end
    endtask

    task automatic run_b();
        int k;
        open_window(1, GB, 4, 1, 1'b0, 0, k);
        drain(1, 4 * GB);
        open_window(1, GB, 4, 0, 1'b0, 5, k);
        drain(1, 4 * GB);
        for (int r = 0; r < 8; r++) begin
            open_window(1, GB, 4, $urandom_range(0, 5), 1'($urandom_range(0, 1)), $urandom_range(0, 3), k);
            drain(1, 4 * GB);
        end
    endtask

    task automatic run_c();
        int c;
        int k;
        int nlow = 0;
        repeat (5) @(posedge clk);
        #1;
        c = cyc;
        k = c + 1;
        fill(2, c + 1, 6 * GC + 20, 4, 1'b0, $urandom_range(0, 7));
        for (int n = 0; n < 5; n++) push(2, model(2, k + n * GC, GC, 16));
        start[2] = 1'b1;
        @(posedge clk);
        #1 start[2] = 1'b0;
        for (int n = 0; n < 5 * GC - 1; n++) begin
            if (!busy[2]) nlow++;
            @(posedge clk);
            #1;
        end
        chk("busy_low_cycles_cont", nlow, 0);
        drain(2, 2 * GC);
        #2 rst_n[2] = 1'b0;
        #1 chk_zero(2, "cont_reset");
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            rst_n[d]  = 1'b0;
            start[d]  = 1'b0;
            nvalid[d] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) chk_zero(d, "reset");
        for (int d = 0; d < 3; d++) rst_n[d] = 1'b1;
        fork
            run_a();
            run_b();
            run_c();
        join
        repeat (5) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #((NCYC - 50) * 10);
        $display("FAIL watchdog: got cycle %0d expected completion before %0d", cyc, NCYC - 50);
        $fatal(1, "watchdog");
    end

endmodule
